// File: rtl/chien_root_checker_if.sv
// -----------------------------------------------------------------------------
// chien_root_checker_if
//   Bundles the sigma/degree input, the Chien beat stream and the result
//   valid/ready port of chien_root_checker into one interface.
//
//   Parameters
//     P  lanes per Chien beat (width of hit_mask_i)
//     T  max correctable symbols (sets the count and degree widths)
//
//   Signals (directions seen from the checker, i.e. the slave modport)
//     sigma_start_i  in   new codeword start, qualified by sigma_valid_i
//     sigma_valid_i  in   sigma/degree valid
//     sigma_deg_i    in   error-locator degree L (DW+1 bits)
//     chien_busy     in   Chien beat active this cycle
//     chien_done     in   last Chien beat (asserted together with chien_busy)
//     hit_mask_i     in   per-lane root hits (P bits)
//     res_ready_i    in   downstream accepts the result
//     res_valid_o    out  result valid, held until accepted
//     root_cnt_o     out  roots found, saturated at T+1 (CW bits)
//     deg_o          out  latched sigma degree (DW+1 bits)
//     fail_o         out  codeword uncorrectable
//     sat_o          out  root count saturated
//     beat_err_o     out  Chien beat sequence malformed
//     busy_o         out  scan in progress
//
//   Modports
//     slave   the checker
//     master  the sigma/Chien producer plus the result consumer
// -----------------------------------------------------------------------------
interface chien_root_checker_if #(
    parameter int unsigned P = 32,
    parameter int unsigned T = 15
);
    localparam int unsigned CW = $clog2(T + 2);
    localparam int unsigned DW = $clog2(T + 1);

    logic          sigma_start_i;
    logic          sigma_valid_i;
    logic [DW:0]   sigma_deg_i;
    logic          chien_busy;
    logic          chien_done;
    logic [P-1:0]  hit_mask_i;
    logic          res_ready_i;
    logic          res_valid_o;
    logic [CW-1:0] root_cnt_o;
    logic [DW:0]   deg_o;
    logic          fail_o;
    logic          sat_o;
    logic          beat_err_o;
    logic          busy_o;

    modport slave (
        input  sigma_start_i,
        input  sigma_valid_i,
        input  sigma_deg_i,
        input  chien_busy,
        input  chien_done,
        input  hit_mask_i,
        input  res_ready_i,
        output res_valid_o,
        output root_cnt_o,
        output deg_o,
        output fail_o,
        output sat_o,
        output beat_err_o,
        output busy_o
    );

    modport master (
        output sigma_start_i,
        output sigma_valid_i,
        output sigma_deg_i,
        output chien_busy,
        output chien_done,
        output hit_mask_i,
        output res_ready_i,
        input  res_valid_o,
        input  root_cnt_o,
        input  deg_o,
        input  fail_o,
        input  sat_o,
        input  beat_err_o,
        input  busy_o
    );
endinterface

// File: rtl/chien_root_checker.sv
// -----------------------------------------------------------------------------
// chien_root_checker
//   Counts Chien search hits over one codeword and decides whether the number
//   of roots found matches the degree of the error-locator polynomial.
//   Each Chien beat carries P candidate positions; a beat counter masks the
//   lanes of the final, partially filled beat and any beat past the end of the
//   codeword. The count saturates at T+1. One result per codeword is offered
//   on a valid/ready port to the Forney/correction controller.
//
//   Parameters
//     P  lanes per Chien beat
//     N  codeword length in symbols
//     T  max correctable symbols
//
//   Ports
//     clk_i   clock
//     rst_ni  asynchronous active-low reset
//     bus     chien_root_checker_if.slave (sigma input, Chien beats, result)
//
//   Result fields
//     root_cnt_o  roots found, saturated at T+1
//     deg_o       degree latched at codeword start
//     fail_o      cnt != deg, deg > T, saturation or beat error
//     sat_o       count reached T+1 (sticky for the codeword)
//     beat_err_o  done not on the last beat, or beats beyond the codeword
//     busy_o      scan in progress
// -----------------------------------------------------------------------------
module chien_root_checker #(
    parameter int unsigned P = 32,
    parameter int unsigned N = 544,
    parameter int unsigned T = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    chien_root_checker_if.slave  bus
);

    localparam int unsigned CW    = $clog2(T + 2);
    localparam int unsigned DW    = $clog2(T + 1);
    localparam int unsigned DEGW  = DW + 1;
    localparam int unsigned NBEAT = (N + P - 1) / P;
    localparam int unsigned LAST  = N - (NBEAT - 1) * P;
    localparam int unsigned BW    = $clog2(NBEAT + 1);
    localparam int unsigned AW    = $clog2(P + 1);
    localparam int unsigned SW    = CW + AW;
    localparam int unsigned CMPW  = (CW > DEGW) ? CW : DEGW;

    // Lanes of the final beat that still fall inside the codeword.
    localparam logic [P-1:0] LAST_MASK = {P{1'b1}} >> (P - LAST);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StHold
    } state_e;

    // State and result registers
    state_e          r_state;
    logic [BW-1:0]   r_beat;
    logic [CW-1:0]   r_cnt;
    logic [DEGW-1:0] r_deg;
    logic            r_sat;
    logic            r_err;
    logic            r_valid;

    // Next-state values
    state_e          w_state_nxt;
    logic [BW-1:0]   w_beat_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [DEGW-1:0] w_deg_nxt;
    logic            w_sat_nxt;
    logic            w_err_nxt;
    logic            w_valid_nxt;

    // Datapath
    logic            w_start;
    logic [P-1:0]    w_lane_mask;
    logic [P-1:0]    w_hits;
    logic [AW-1:0]   w_addend;
    logic [SW-1:0]   w_sum;
    logic            w_fail;

    assign w_start = bus.sigma_start_i & bus.sigma_valid_i;

    // Beats before the last are fully inside the codeword, the last one only
    // partially, and anything after it contributes nothing.
    always_comb begin
        w_lane_mask = '0;
        if (r_beat < BW'(NBEAT - 1)) begin
            w_lane_mask = '1;
        end else if (r_beat == BW'(NBEAT - 1)) begin
            w_lane_mask = LAST_MASK;
        end
    end

    assign w_hits = bus.hit_mask_i & w_lane_mask;

    always_comb begin
        w_addend = '0;
        for (int i = 0; i < int'(P); i++) begin
            w_addend = w_addend + AW'(w_hits[i]);
        end
    end

    // Wide enough that cnt (<= T+1) plus a full beat cannot wrap.
    assign w_sum = SW'(r_cnt) + SW'(w_addend);

    // Next-state / register update logic
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_cnt_nxt   = r_cnt;
        w_deg_nxt   = r_deg;
        w_sat_nxt   = r_sat;
        w_err_nxt   = r_err;
        w_valid_nxt = r_valid;

        if (w_start) begin
            // A new codeword wins over everything, including a result that
            // has not been accepted yet.
            w_state_nxt = StScan;
            w_beat_nxt  = '0;
            w_cnt_nxt   = '0;
            w_deg_nxt   = bus.sigma_deg_i;
            w_sat_nxt   = 1'b0;
            w_err_nxt   = 1'b0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                StScan: begin
                    if (bus.chien_busy) begin
                        if (w_sum > SW'(T)) begin
                            w_cnt_nxt = CW'(T + 1);
                            w_sat_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = CW'(w_sum);
                        end

                        if (r_beat >= BW'(NBEAT)) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_beat_nxt = r_beat + BW'(1);
                        end

                        if (bus.chien_done) begin
                            if (r_beat != BW'(NBEAT - 1)) begin
                                w_err_nxt = 1'b1;
                            end
                            w_valid_nxt = 1'b1;
                            w_state_nxt = StHold;
                        end
                    end
                end
                StHold: begin
                    if (r_valid && bus.res_ready_i) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = StIdle;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_beat  <= '0;
            r_cnt   <= '0;
            r_deg   <= '0;
            r_sat   <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_cnt   <= w_cnt_nxt;
            r_deg   <= w_deg_nxt;
            r_sat   <= w_sat_nxt;
            r_err   <= w_err_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Zero degree with zero roots is a clean codeword.
    assign w_fail = (CMPW'(r_cnt) != CMPW'(r_deg)) | (r_deg > DEGW'(T)) | r_sat | r_err;

    assign bus.res_valid_o = r_valid;
    assign bus.root_cnt_o  = r_cnt;
    assign bus.deg_o       = r_deg;
    assign bus.fail_o      = w_fail;
    assign bus.sat_o       = r_sat;
    assign bus.beat_err_o  = r_err;
    assign bus.busy_o      = (r_state == StScan);

`ifndef SYNTHESIS
    // Producer protocol: a done flag is only meaningful on an active beat.
    a_done_with_busy: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        bus.chien_done |-> bus.chien_busy
    );

    // A presented result may only be withdrawn by a handshake or a new start.
    a_valid_held: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (r_valid && !bus.res_ready_i && !w_start) |=> r_valid
    );
`endif

endmodule

// File: tb/tb_chien_root_checker.sv
// -----------------------------------------------------------------------------
// tb_chien_root_checker
//   Two checkers (P=32 and P=48, N=544, T=15) receive the same beat stream;
//   the P=32 instance sees the low 32 lanes of each 48-bit mask. Expected
//   results come from counting hit positions that lie inside the codeword and
//   comparing the beat count with ceil(N/P). Monitors pop the expectations
//   whenever a result is presented.
// -----------------------------------------------------------------------------
module tb_chien_root_checker;

    localparam int unsigned N  = 544;
    localparam int unsigned T  = 15;
    localparam int unsigned PA = 32;
    localparam int unsigned PB = 48;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    chien_root_checker_if #(.P(PA), .T(T)) if_a ();
    chien_root_checker_if #(.P(PB), .T(T)) if_b ();

    chien_root_checker #(.P(PA), .N(N), .T(T)) u_dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if_a.slave)
    );

    chien_root_checker #(.P(PB), .N(N), .T(T)) u_dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if_b.slave)
    );

    typedef struct {
        int cnt;
        int deg;
        int fail;
        int sat;
        int err;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [47:0] cw_mask[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic cmp_res(input string nm, input int cnt, input int deg, input int fail,
                           input int sat, input int err, input exp_t e);
        n_tests++;
        if (cnt != e.cnt || deg != e.deg || fail != e.fail || sat != e.sat || err != e.err) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d deg=%0d fail=%0d sat=%0d err=%0d, expected cnt=%0d deg=%0d fail=%0d sat=%0d err=%0d",
                     nm, cnt, deg, fail, sat, err, e.cnt, e.deg, e.fail, e.sat, e.err);
        end
    endtask

    // Raw number of hits at symbol positions inside the codeword.
    function automatic int hits_in(input int p);
        int h = 0;
        for (int k = 0; k < cw_mask.size(); k++) begin
            for (int l = 0; l < p; l++) begin
                if (cw_mask[k][l] && (k * p + l) < int'(N)) h++;
            end
        end
        return h;
    endfunction

    function automatic exp_t model(input int p, input int deg);
        exp_t e;
        int   h     = hits_in(p);
        int   nbeat = (int'(N) + p - 1) / p;
        e.sat  = (h > int'(T)) ? 1 : 0;
        e.cnt  = e.sat ? int'(T) + 1 : h;
        e.deg  = deg;
        e.err  = (cw_mask.size() != nbeat) ? 1 : 0;
        e.fail = (e.cnt != deg || deg > int'(T) || e.sat != 0 || e.err != 0) ? 1 : 0;
        return e;
    endfunction

    task automatic drive(input bit st, input bit sv, input int deg, input bit busy,
                         input bit done, input logic [47:0] m);
        if_a.sigma_start_i = st;
        if_b.sigma_start_i = st;
        if_a.sigma_valid_i = sv;
        if_b.sigma_valid_i = sv;
        if_a.sigma_deg_i   = 5'(deg);
        if_b.sigma_deg_i   = 5'(deg);
        if_a.chien_busy    = busy;
        if_b.chien_busy    = busy;
        if_a.chien_done    = done;
        if_b.chien_done    = done;
        if_a.hit_mask_i    = m[31:0];
        if_b.hit_mask_i    = m;
    endtask

    task automatic set_ready(input bit r);
        if_a.res_ready_i = r;
        if_b.res_ready_i = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_a"}, int'({if_a.res_valid_o, if_a.root_cnt_o, if_a.deg_o, if_a.fail_o,
                              if_a.sat_o, if_a.beat_err_o, if_a.busy_o}), 0);
        chk({nm, "_b"}, int'({if_b.res_valid_o, if_b.root_cnt_o, if_b.deg_o, if_b.fail_o,
                              if_b.sat_o, if_b.beat_err_o, if_b.busy_o}), 0);
    endtask

    // Runs the codeword held in cw_mask. keep=1 leaves the result pending.
    task automatic run_cw(input int deg, input int delay, input bit keep);
        int last = cw_mask.size() - 1;
        q_a.push_back(model(int'(PA), deg));
        q_b.push_back(model(int'(PB), deg));
        drive(1, 1, deg, 0, 0, '0);
        step();
        drive(0, 0, 0, 0, 0, '0);
        chk("start_valid_a", if_a.res_valid_o, 0);
        chk("start_busy_a", if_a.busy_o, 1);
        chk("start_cnt_b", if_b.root_cnt_o, 0);
        chk("start_deg_b", if_b.deg_o, deg);
        for (int k = 0; k <= last; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                drive(0, 0, 0, 0, 0, 48'({$urandom(), $urandom()}));
                step();
            end
            drive(0, 0, 0, 1, (k == last), cw_mask[k]);
            step();
        end
        drive(0, 0, 0, 0, 0, '0);
        chk("latency_valid_a", if_a.res_valid_o, 1);
        chk("latency_valid_b", if_b.res_valid_o, 1);
        chk("hold_busy_a", if_a.busy_o, 0);
        if (!keep) begin
            repeat (delay) step();
            set_ready(1);
            step();
            set_ready(0);
            chk("accept_valid_a", if_a.res_valid_o, 0);
            chk("accept_valid_b", if_b.res_valid_o, 0);
        end
    endtask

    task automatic blank_cw(input int nbeats);
        cw_mask.delete();
        for (int k = 0; k < nbeats; k++) cw_mask.push_back('0);
    endtask

    task automatic gen_random_cw(output int deg);
        int   nb;
        int   pick = int'($urandom_range(0, 3));
        logic [47:0] m;
        nb = (pick == 0) ? 17 : (pick == 1) ? 12 : int'($urandom_range(1, 20));
        cw_mask.delete();
        for (int k = 0; k < nb; k++) begin
            m = '0;
            case ($urandom_range(0, 11))
                0:       m = 48'({$urandom(), $urandom()});
                1, 2, 3: m[$urandom_range(0, 47)] = 1'b1;
                default: m = '0;
            endcase
            cw_mask.push_back(m);
        end
        case ($urandom_range(0, 3))
            0:       deg = int'($urandom_range(0, 20));
            1:       deg = hits_in(int'(PB));
            default: deg = hits_in(int'(PA));
        endcase
        if (deg > 31) deg = 31;
    endtask

    // Result monitors
    exp_t cur_a, cur_b;
    bit   seen_a = 1'b0, seen_b = 1'b0, have_a = 1'b0, have_b = 1'b0;

    always @(negedge clk) begin
        if (rst_n && if_a.res_valid_o) begin
            if (!seen_a) begin
                seen_a = 1'b1;
                have_a = (q_a.size() != 0);
                if (have_a) cur_a = q_a.pop_front();
                else chk("unexpected_result_a", 1, 0);
            end
            if (have_a) cmp_res("result_a", int'(if_a.root_cnt_o), int'(if_a.deg_o),
                                int'(if_a.fail_o), int'(if_a.sat_o), int'(if_a.beat_err_o), cur_a);
        end else begin
            seen_a = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && if_b.res_valid_o) begin
            if (!seen_b) begin
                seen_b = 1'b1;
                have_b = (q_b.size() != 0);
                if (have_b) cur_b = q_b.pop_front();
                else chk("unexpected_result_b", 1, 0);
            end
            if (have_b) cmp_res("result_b", int'(if_b.root_cnt_o), int'(if_b.deg_o),
                                int'(if_b.fail_o), int'(if_b.sat_o), int'(if_b.beat_err_o), cur_b);
        end else begin
            seen_b = 1'b0;
        end
    end

    initial begin
        int deg;
        drive(0, 0, 0, 0, 0, '0);
        set_ready(0);
        #2 rst_n = 1'b0;
        #3 chk_zero("reset");
        step();
        rst_n = 1'b1;
        step();
        chk_zero("after_reset");

        // start without sigma_valid, and sigma_valid without start: no scan
        drive(1, 0, 3, 0, 0, '0);
        step();
        chk("start_unqualified_a", if_a.busy_o, 0);
        drive(0, 1, 3, 0, 0, '0);
        step();
        chk("valid_no_start_b", if_b.busy_o, 0);
        drive(0, 0, 0, 0, 0, '0);

        // Three roots over 17 beats, degree 3, then degree 4; ready held off 5 cycles
        blank_cw(17);
        cw_mask[0][5]   = 1'b1;
        cw_mask[9][0]   = 1'b1;
        cw_mask[16][31] = 1'b1;
        run_cw(3, 5, 0);
        run_cw(4, 0, 0);

        // Last P=48 beat all ones: only 16 lanes inside the codeword
        blank_cw(12);
        cw_mask[11] = 48'hFFFF_FFFF_FFFF;
        run_cw(5, 1, 0);

        // Done early (11 beats), degree 0
        blank_cw(11);
        run_cw(0, 0, 0);

        // 18 beats, hit on the extra beat is ignored
        blank_cw(18);
        cw_mask[0][1]  = 1'b1;
        cw_mask[17][2] = 1'b1;
        run_cw(1, 2, 0);

        // Start while a result is pending aborts it
        blank_cw(17);
        cw_mask[3][7] = 1'b1;
        run_cw(1, 0, 1);
        repeat (2) step();
        blank_cw(17);
        cw_mask[4][8]  = 1'b1;
        cw_mask[5][40] = 1'b1;
        run_cw(2, 1, 0);

        // Asynchronous reset in the middle of a scan
        drive(1, 1, 7, 0, 0, '0);
        step();
        drive(0, 0, 0, 1, 0, 48'h3);
        step();
        step();
        #3 rst_n = 1'b0;
        #1 chk_zero("reset_mid_scan");
        drive(0, 0, 0, 0, 0, '0);
        step();
        rst_n = 1'b1;
        step();

        // Asynchronous reset while holding a result
        blank_cw(12);
        cw_mask[2][20] = 1'b1;
        run_cw(1, 0, 1);
        step();
        #3 rst_n = 1'b0;
        #1 chk_zero("reset_mid_hold");
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 40; i++) begin
            gen_random_cw(deg);
            run_cw(deg, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
        blank_cw(17);
        run_cw(0, 0, 0);
        step();

        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
